multicycle_control_unit: RTL and testbench

Moore-style FSM controller for the multi-cycle RV32I datapath, successor to the single-cycle control top. It sequences each instruction over 3–5 cycles through a shared ALU and unified memory and waits on a memory-ready handshake. Parameters enable full branch compare, upper-immediate ops, JALR, and a trap-halt mode. It drives the PC, IR, ALUOut-path muxes and register-file / memory write enables.

---
 rtl/multicycle_control_unit.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing RV32I instructions over a shared ALU and unified memory.
// Outputs decode from the current state, with mem_ready and ALU flags folded in where a state waits or branches.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W     = 4,
   parameter bit EN_FULL_BRANCH = 1'b1,
   parameter bit EN_UPPER       = 1'b1,
   parameter bit EN_JALR        = 1'b1,
   parameter bit TRAP_HALT      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            Op,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic                  Zero,
   input  logic                  Lt,
   input  logic                  Ltu,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  IRWrite,
   output logic                  RegWrite,
   output logic                  MemWrite,
   output logic                  AdrSrc,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ResultSrc,
   output logic [2:0]            ImmSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  illegal_op,
   output logic [3:0]            state
);
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3, S_MEMWB = 4'd4,
      S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9,
      S_JAL = 4'd10, S_JALR = 4'd11, S_UPPER = 4'd12, S_TRAP = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
   localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0), ALU_SUB = ALU_CTRL_W'(1),
      ALU_AND = ALU_CTRL_W'(2), ALU_OR = ALU_CTRL_W'(3), ALU_XOR = ALU_CTRL_W'(4),
      ALU_SLT = ALU_CTRL_W'(5), ALU_SLTU = ALU_CTRL_W'(6), ALU_SLL = ALU_CTRL_W'(7),
      ALU_SRL = ALU_CTRL_W'(8), ALU_SRA = ALU_CTRL_W'(9);

   state_t                r_state, w_next, w_dec;
   logic                  r_illegal;
   logic                  w_br_ok, w_taken, w_pcw, w_irw, w_rw, w_mw, w_unused;
   logic [ALU_CTRL_W-1:0] w_alu_f;

   assign w_unused = &{1'b0, funct7[6], funct7[4:0]};
   // 010/011 are never branches; 1xx compares only exist with the full comparator
   assign w_br_ok  = (funct3[2:1] != 2'b01) && (EN_FULL_BRANCH || !funct3[2]);

   always_comb begin
      case (Op)
         OP_LOAD, OP_STORE: w_dec = S_MEMADR;
         OP_R:              w_dec = S_EXECR;
         OP_I:              w_dec = S_EXECI;
         OP_BRANCH:         w_dec = w_br_ok ? S_BRANCH : S_TRAP;
         OP_JAL:            w_dec = S_JAL;
         OP_JALR:           w_dec = EN_JALR ? S_JALR : S_TRAP;
         OP_LUI, OP_AUIPC:  w_dec = EN_UPPER ? S_UPPER : S_TRAP;
         default:           w_dec = S_TRAP;
      endcase
   end

   always_comb begin
      case (r_state)
         S_FETCH:                    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:                   w_next = w_dec;
         S_MEMADR:                   w_next = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:                  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE:                 w_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR, S_EXECI, S_UPPER:  w_next = S_ALUWB;
         S_JAL:                      w_next = S_ALUWB;
         S_JALR:                     w_next = S_JAL;
         S_TRAP:                     w_next = TRAP_HALT ? S_TRAP : S_FETCH;
         default:                    w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      case (funct3)
         3'b000:  w_alu_f = (r_state == S_EXECR && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  w_alu_f = ALU_SLL;
         3'b010:  w_alu_f = ALU_SLT;
         3'b011:  w_alu_f = ALU_SLTU;
         3'b100:  w_alu_f = ALU_XOR;
         3'b101:  w_alu_f = funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  w_alu_f = ALU_OR;
         default: w_alu_f = ALU_AND;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  w_taken = Zero;
         3'b001:  w_taken = !Zero;
         3'b100:  w_taken = Lt;
         3'b101:  w_taken = !Lt;
         3'b110:  w_taken = Ltu;
         3'b111:  w_taken = !Ltu;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      w_pcw      = 1'b0;
      w_irw      = 1'b0;
      w_rw       = 1'b0;
      w_mw       = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ImmSrc     = IMM_I;
      ALUControl = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            w_pcw     = mem_ready;
            w_irw     = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = (Op == OP_BRANCH) ? IMM_B : (Op == OP_JAL) ? IMM_J : IMM_I;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (Op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            w_rw      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            w_mw   = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = w_alu_f;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = w_alu_f;
         end
         S_ALUWB: w_rw = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            w_pcw      = w_taken;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            w_pcw   = 1'b1;
         end
         S_JALR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_UPPER: begin
            ALUSrcA = (Op == OP_LUI) ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = IMM_U;
         end
         default: ;
      endcase
   end

   // reset gates enables combinationally so nothing writes while rst is high
   assign PCWrite    = w_pcw & ~rst;
   assign IRWrite    = w_irw & ~rst;
   assign RegWrite   = w_rw & ~rst;
   assign MemWrite   = w_mw & ~rst;
   assign illegal_op = r_illegal;
   assign state      = r_state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random instruction streams into a full-feature and a reduced/non-halting
// controller, each cycle's expected outputs queued by a reference model and checked by a monitor.
module tb_multicycle_control_unit;
   typedef struct packed {logic [6:0] op; logic [2:0] f3; logic [6:0] f7;} ins_t;
   typedef struct packed {logic lane; logic [22:0] v; int cyc;} rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  op [2];
   logic [6:0]  f7 [2];
   logic [2:0]  f3 [2];
   logic        zf [2], lt [2], ltu [2], mr [2];
   logic [22:0] obs [2];
   int          path [2][6];
   int          plen [2], pidx [2];
   logic        ill [2];
   int          mr_force = 1;
   int          n_cmp = 0, n_bad = 0, cyc = 0;
   ins_t        dq0 [$], dq1 [$];
   rec_t        sq [$];

   always #5 clk = ~clk;

   // lane 0: every feature on, halts in TRAP; lane 1: optional features off, TRAP returns to FETCH
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       pcw, irw, rw, mw, adr, il;
      logic [1:0] a, b, rs;
      logic [2:0] imm;
      logic [3:0] alu, st;
      multicycle_control_unit #(.ALU_CTRL_W(4), .EN_FULL_BRANCH(g == 0), .EN_UPPER(g == 0),
                                .EN_JALR(g == 0), .TRAP_HALT(g == 0)) u_dut (
         .clk(clk), .rst(rst), .Op(op[g]), .funct3(f3[g]), .funct7(f7[g]), .Zero(zf[g]),
         .Lt(lt[g]), .Ltu(ltu[g]), .mem_ready(mr[g]), .PCWrite(pcw), .IRWrite(irw),
         .RegWrite(rw), .MemWrite(mw), .AdrSrc(adr), .ALUSrcA(a), .ALUSrcB(b),
         .ResultSrc(rs), .ImmSrc(imm), .ALUControl(alu), .illegal_op(il), .state(st));
      assign obs[g] = {st, pcw, irw, rw, mw, adr, a, b, rs, imm, alu, il};
   end

   function automatic logic [22:0] expv(int ph, ins_t i, logic m, logic z, logic l, logic lu, logic il);
      logic       pcw, irw, rw, mw, adr, cond;
      logic [1:0] a, b, rs;
      logic [2:0] imm;
      logic [3:0] alu;
      logic [3:0] tbl [8];
      {pcw, irw, rw, mw, adr, a, b, rs, imm, alu} = '0;
      tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
      if (ph == 6 || ph == 7) begin
         alu = tbl[i.f3];
         if (i.f3 == 3'd0 && ph == 6 && i.f7[5]) alu = 4'd1;
         if (i.f3 == 3'd5 && i.f7[5]) alu = 4'd9;
      end
      cond = (i.f3[2] ? (i.f3[1] ? lu : l) : z) ^ i.f3[0];
      case (ph)
         0:  begin b = 2; rs = 2; pcw = m; irw = m; end
         1:  begin a = 1; b = 1; imm = (i.op == 7'b1100011) ? 3'd2 : (i.op == 7'b1101111) ? 3'd3 : 3'd0; end
         2:  begin a = 2; b = 1; imm = (i.op == 7'b0100011) ? 3'd1 : 3'd0; end
         3:  adr = 1;
         4:  begin rs = 1; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  a = 2;
         7:  begin a = 2; b = 1; end
         8:  rw = 1;
         9:  begin a = 2; alu = 4'd1; pcw = cond; end
         10: begin a = 1; b = 2; pcw = 1; end
         11: begin a = 2; b = 1; end
         12: begin imm = 3'd4; b = 1; a = (i.op == 7'b0110111) ? 2'd3 : 2'd1; end
         default: ;
      endcase
      return {4'(ph), pcw, irw, rw, mw, adr, a, b, rs, imm, alu, il};
   endfunction

   function automatic ins_t rand_ins(int k);
      logic [6:0] ops [9];
      ins_t       i;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      i.op = ops[$urandom_range(8)];
      if (k == 1 && $urandom_range(5) == 0) i.op = 7'($urandom);
      i.f3 = 3'($urandom);
      i.f7 = 7'($urandom);
      if (k == 0 && i.op == 7'b1100011 && i.f3[2:1] == 2'b01) i.f3[2] = 1'b1;
      return i;
   endfunction

   task automatic new_ins(int k);
      ins_t i;
      logic full, br_ok;
      full = (k == 0);
      if (k == 0 && dq0.size() > 0) i = dq0.pop_front();
      else if (k == 1 && dq1.size() > 0) i = dq1.pop_front();
      else i = rand_ins(k);
      op[k] = i.op;
      f3[k] = i.f3;
      f7[k] = i.f7;
      br_ok = (i.f3 != 3'd2 && i.f3 != 3'd3) && (full || i.f3 < 3'd4);
      path[k] = '{0, 1, 13, 0, 0, 0};
      plen[k] = 3;
      case (i.op)
         7'b0000011: begin path[k] = '{0, 1, 2, 3, 4, 0}; plen[k] = 5; end
         7'b0100011: begin path[k] = '{0, 1, 2, 5, 0, 0}; plen[k] = 4; end
         7'b0110011: begin path[k] = '{0, 1, 6, 8, 0, 0}; plen[k] = 4; end
         7'b0010011: begin path[k] = '{0, 1, 7, 8, 0, 0}; plen[k] = 4; end
         7'b1100011: if (br_ok) path[k] = '{0, 1, 9, 0, 0, 0};
         7'b1101111: begin path[k] = '{0, 1, 10, 8, 0, 0}; plen[k] = 4; end
         7'b1100111: if (full) begin path[k] = '{0, 1, 11, 10, 8, 0}; plen[k] = 5; end
         7'b0110111, 7'b0010111: if (full) begin path[k] = '{0, 1, 12, 8, 0, 0}; plen[k] = 4; end
         default: ;
      endcase
      pidx[k] = 0;
   endtask

   task automatic lane_step(int k, logic r);
      int   ph;
      ins_t i;
      zf[k]  = 1'($urandom_range(1));
      lt[k]  = 1'($urandom_range(1));
      ltu[k] = 1'($urandom_range(1));
      mr[k]  = (mr_force >= 0) ? 1'(mr_force) : ($urandom_range(9) < 7);
      if (r) begin
         pidx[k] = 0;
         plen[k] = 0;
         ill[k]  = 1'b0;
         sq.push_back('{1'(k), expv(0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), cyc});
         return;
      end
      if (pidx[k] == plen[k]) new_ins(k);
      ph = path[k][pidx[k]];
      if (ph == 13) ill[k] = 1'b1;
      i = '{op[k], f3[k], f7[k]};
      sq.push_back('{1'(k), expv(ph, i, mr[k], zf[k], lt[k], ltu[k], ill[k]), cyc});
      if (!((ph == 0 || ph == 3 || ph == 5) && !mr[k]) && !(ph == 13 && k == 0)) pidx[k]++;
   endtask

   task automatic step(logic r);
      rst = r;
      for (int k = 0; k < 2; k++) lane_step(k, r);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         while (sq.size() > 0) begin
            e = sq.pop_front();
            n_cmp++;
            if (obs[e.lane] !== e.v) begin
               n_bad++;
               $display("FAIL out_lane%0d_cyc%0d got=%h exp=%h", e.lane, e.cyc, obs[e.lane], e.v);
            end
         end
      end
   end

   initial begin
      int pat [8];
      pat = '{0, 0, 1, 1, 1, 0, 1, 1};
      for (int k = 0; k < 2; k++) begin
         op[k] = '0; f3[k] = '0; f7[k] = '0; zf[k] = 0; lt[k] = 0; ltu[k] = 0; mr[k] = 0;
         plen[k] = 0; pidx[k] = 0; ill[k] = 0;
      end
      repeat (2) begin
         dq0.push_back('{7'b0000011, 3'b010, 7'd0});
         dq1.push_back('{7'b0000011, 3'b010, 7'd0});
      end
      dq0.push_back('{7'b0110011, 3'b000, 7'b0100000});
      dq0.push_back('{7'b1100011, 3'b001, 7'd0});
      dq0.push_back('{7'b1100011, 3'b101, 7'd0});
      dq0.push_back('{7'b1100111, 3'b000, 7'd0});
      dq1.push_back('{7'b1100011, 3'b100, 7'd0});
      dq1.push_back('{7'b0110111, 3'b000, 7'd0});
      dq1.push_back('{7'b1100111, 3'b000, 7'd0});
      dq1.push_back('{7'b1100011, 3'b010, 7'd0});
      dq1.push_back('{7'b1111111, 3'b000, 7'd0});
      #1;
      step(1);
      step(1);
      for (int j = 0; j < 8; j++) begin
         mr_force = pat[j];
         step(0);
      end
      // second load is interrupted by reset while stalled in MEMREAD
      mr_force = 1;
      repeat (3) step(0);
      mr_force = 0;
      step(0);
      step(1);
      mr_force = -1;
      repeat (400) step(0);
      mr_force = 1;
      dq0.push_back('{7'b1111111, 3'b000, 7'd0});
      dq1.push_back('{7'b1111111, 3'b000, 7'd0});
      repeat (20) step(0);
      @(negedge clk);
      #1;
      n_cmp++;
      if (sq.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d exp=0", sq.size());
      end
      n_cmp++;
      if (obs[0][22:19] !== 4'd13 || obs[0][0] !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_lane0 got_state=%0d got_ill=%b exp_state=13 exp_ill=1", obs[0][22:19], obs[0][0]);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
